srv_icache_refill: RTL and testbench

SRV_ICACHE_REFILL -- requirements
Module: srv_icache_refill

---
 rtl/srv_icache_refill.sv | 170 +++++++++++++++++
 tb/tb_srv_icache_refill.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/srv_icache_refill.sv
// Instruction-cache line refill engine: fetches one 4-word line over an in-order memory port.
// Optional macro SRV_REFILL_CWF_EN: fetch the critical word first (otherwise words 0..3 in order).
module srv_icache_refill #(
    parameter int unsigned LINE_WORDS  = 4,
    parameter int unsigned MEM_LAT_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_i,
    input  logic [31:0]                addr_i,
    output logic                       rsp_o,
    output logic [LINE_WORDS*32-1:0]   line_o,
    output logic                       busy_o,
    output logic                       mem_req_o,
    output logic [31:0]                mem_addr_o,
    input  logic                       mem_gnt_i,
    input  logic                       mem_rvalid_i,
    input  logic [31:0]                mem_rdata_i
);

    localparam int unsigned LAT_CNT_W = $clog2(MEM_LAT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [27:0]              base_q, base_d;
    logic [1:0]               start_q, start_d;
    logic [1:0]               issue_idx_q, issue_idx_d;
    logic [2:0]               issued_cnt_q, issued_cnt_d;
    logic [2:0]               rcv_cnt_q, rcv_cnt_d;
    logic [LINE_WORDS*32-1:0] line_q, line_d;
    logic                     rsp_q, rsp_d;
    logic                     busy_q, busy_d;
    logic                     mem_req_q, mem_req_d;
    logic [31:0]              mem_addr_q, mem_addr_d;

    logic [1:0]               start_idx_s;
    logic [1:0]               word_sel_s;
    logic [6:0]               word_lsb_s;
    logic                     capture_s;
    logic [3:0]               unused_addr_s;
    logic [LAT_CNT_W-1:0]     unused_lat_s;

`ifdef SRV_REFILL_CWF_EN
    assign start_idx_s   = addr_i[3:2];
    assign unused_addr_s = {2'b00, addr_i[1:0]};
`else
    assign start_idx_s   = 2'd0;
    assign unused_addr_s = addr_i[3:0];
`endif
    assign unused_lat_s  = {LAT_CNT_W{1'b0}};

    // Responses return in request order, so the n-th response always lands in word start+n.
    assign word_sel_s = start_q + rcv_cnt_q[1:0];
    assign word_lsb_s = {word_sel_s, 5'd0};
    assign capture_s  = mem_rvalid_i && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));

    // Next-state, counter, line-assembly and registered-output computation.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        start_d      = start_q;
        issue_idx_d  = issue_idx_q;
        issued_cnt_d = issued_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        line_d       = line_q;

        if (capture_s) begin
            line_d[word_lsb_s +: 32] = mem_rdata_i;
            rcv_cnt_d                = rcv_cnt_q + 3'd1;
        end else begin
            rcv_cnt_d = rcv_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    base_d       = addr_i[31:4];
                    start_d      = start_idx_s;
                    issue_idx_d  = start_idx_s;
                    issued_cnt_d = 3'd0;
                    rcv_cnt_d    = 3'd0;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt_i && mem_req_q) begin
                    issue_idx_d  = issue_idx_q + 2'd1;
                    issued_cnt_d = issued_cnt_q + 3'd1;
                end else begin
                    issue_idx_d  = issue_idx_q;
                    issued_cnt_d = issued_cnt_q;
                end
                if (rcv_cnt_d == 3'd4) begin
                    state_d = ST_DONE;
                end else if (issued_cnt_d == 3'd4) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (rcv_cnt_d == 3'd4) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_d     = (state_d == ST_DONE);
        busy_d    = (state_d != ST_IDLE);
        mem_req_d = (state_d == ST_ISSUE);
        if (mem_req_d) begin
            mem_addr_d = {base_d, issue_idx_d, 2'b00};
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    // Control state and outputs, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issue_idx_q  <= 2'd0;
            issued_cnt_q <= 3'd0;
            rcv_cnt_q    <= 3'd0;
            rsp_q        <= 1'b0;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            issue_idx_q  <= issue_idx_d;
            issued_cnt_q <= issued_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            rsp_q        <= rsp_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // Datapath storage: line buffer and latched miss address are deliberately not reset.
    always_ff @(posedge clk) begin
        base_q  <= base_d;
        start_q <= start_d;
        line_q  <= line_d;
    end

    assign rsp_o      = rsp_q;
    assign busy_o     = busy_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign line_o     = line_q;

endmodule

// File: tb/tb_srv_icache_refill.sv
// Self-checking bench for srv_icache_refill: a behavioural memory plus a line/fetch-order reference model.
module tb_srv_icache_refill;

    localparam int unsigned MEM_LAT_MAX = 8;
`ifdef SRV_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_i;
    logic [31:0]  addr_i;
    logic         rsp_o;
    logic [127:0] line_o;
    logic         busy_o;
    logic         mem_req_o;
    logic [31:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [31:0]  mem_rdata_i;

    always #5 clk = ~clk;

    srv_icache_refill #(.LINE_WORDS(4), .MEM_LAT_MAX(MEM_LAT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i),
        .rsp_o(rsp_o), .line_o(line_o), .busy_o(busy_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // Main-thread controls
    int          gnt_mode;
    bit          lat_rand;
    int          spur_req;
    logic [31:0] salt;

    // Memory-model state
    int          cyc;
    logic [31:0] pend_q[$];
    int          due_q[$];
    int          last_due;
    logic [31:0] grant_log[$];
    int          rsp_cnt;
    int          stab_err;
    int          max_out;
    int          stall_cnt;
    int          spur_done;
    bit          prev_stall;
    logic [31:0] prev_addr;

    int n_checks;
    int n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic logic [127:0] exp_line(input logic [31:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_word({a[31:4], 4'h0} + 32'(4 * k));
        return l;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: grants, in-order responses with latency, and protocol bookkeeping.
    initial begin
        logic [31:0] a;
        bit g;
        int d;
        cyc = 0; last_due = 0; rsp_cnt = 0; stab_err = 0; max_out = 0;
        stall_cnt = 0; spur_done = 0; prev_stall = 1'b0; prev_addr = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n !== 1'b1) begin
                pend_q.delete(); due_q.delete();
                last_due = 0; prev_stall = 1'b0;
                mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            end else begin
                if (prev_stall && (mem_addr_o !== prev_addr)) stab_err++;
                if (rsp_o === 1'b1) rsp_cnt++;
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    a = pend_q.pop_front();
                    void'(due_q.pop_front());
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = mem_word(a);
                end else if (spur_req != spur_done && pend_q.size() == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = 32'hDEAD_BEEF;
                    spur_done++;
                end else begin
                    mem_rvalid_i = 1'b0;
                    mem_rdata_i  = $urandom();
                end
                g = 1'b0;
                if (mem_req_o === 1'b1) begin
                    if (gnt_mode == 1) g = ($urandom_range(0, 99) < 60);
                    else if (gnt_mode == 2 && (grant_log.size() % 4) == 1 && stall_cnt < 3) begin
                        g = 1'b0;
                        stall_cnt++;
                    end else g = 1'b1;
                end
                mem_gnt_i = g;
                if (g) begin
                    grant_log.push_back(mem_addr_o);
                    d = cyc + (lat_rand ? int'($urandom_range(1, MEM_LAT_MAX)) : 1);
                    if (due_q.size() > 0 && d <= last_due) d = last_due + 1;
                    pend_q.push_back(mem_addr_o);
                    due_q.push_back(d);
                    last_due = d;
                    if (pend_q.size() > max_out) max_out = pend_q.size();
                end
                prev_stall = (mem_req_o === 1'b1) && !g;
                prev_addr  = mem_addr_o;
            end
        end
    end

    task automatic wait_rsp(input string tag, input bit hold, output int n);
        bit got;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (!hold) begin req_i = 1'b0; addr_i = $urandom(); end
            if (n == 1) check($sformatf("%s_busy", tag), {127'd0, busy_o}, 128'd1);
            if (rsp_o === 1'b1) got = 1'b1;
        end
        check($sformatf("%s_rsp_seen", tag), {127'd0, got}, 128'd1);
    endtask

    task automatic check_grants(input string tag, input logic [31:0] addr, input int gstart);
        int st;
        logic [31:0] ea;
        st = CWF ? int'(addr[3:2]) : 0;
        check($sformatf("%s_nreq", tag), 128'(grant_log.size() - gstart), 128'd4);
        if (grant_log.size() >= gstart + 4) begin
            for (int k = 0; k < 4; k++) begin
                ea = {addr[31:4], 4'h0} + 32'(((st + k) % 4) * 4);
                check($sformatf("%s_addr%0d", tag, k), {96'd0, grant_log[gstart + k]}, {96'd0, ea});
            end
        end
    endtask

    task automatic full_fill(input string tag, input logic [31:0] addr, input bit chk_lat);
        int gstart, rstart, n;
        gstart = grant_log.size();
        rstart = rsp_cnt;
        req_i = 1'b1; addr_i = addr;
        wait_rsp(tag, 1'b0, n);
        if (chk_lat) check($sformatf("%s_latency", tag), 128'(n), 128'd6);
        check($sformatf("%s_line", tag), line_o, exp_line(addr));
        repeat (2) @(negedge clk);
        check_grants(tag, addr, gstart);
        check($sformatf("%s_rsp_once", tag), 128'(rsp_cnt - rstart), 128'd1);
    endtask

    initial begin
        int gstart, rstart, n;
        logic [127:0] saved;
        logic [31:0] a;
        n_checks = 0; n_fail = 0;
        gnt_mode = 0; lat_rand = 1'b0; spur_req = 0; salt = 32'h0;
        req_i = 1'b0; addr_i = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rsp", {127'd0, rsp_o}, 128'd0);
        check("reset_busy", {127'd0, busy_o}, 128'd0);
        check("reset_memreq", {127'd0, mem_req_o}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Minimum-latency fill at 0x1008 (critical word 2)
        salt = 32'h1357_9BDF;
        full_fill("dir1008", 32'h0000_1008, 1'b1);

        // Grant withheld for three cycles on the second request
        gnt_mode = 2; salt = $urandom();
        full_fill("stall", 32'h0000_2004, 1'b0);
        check("stall_cycles", 128'(stall_cnt), 128'd3);
        check("stall_addr_stable", 128'(stab_err), 128'd0);
        gnt_mode = 0;

        // req_i held high: DONE returns to IDLE before a second fill starts
        gstart = grant_log.size(); rstart = rsp_cnt;
        a = 32'h0000_300C; req_i = 1'b1; addr_i = a;
        wait_rsp("hold1", 1'b1, n);
        @(negedge clk);
        check("hold_idle_busy", {127'd0, busy_o}, 128'd0);
        check("hold_idle_memreq", {127'd0, mem_req_o}, 128'd0);
        @(negedge clk);
        check("hold_restart_busy", {127'd0, busy_o}, 128'd1);
        check("hold_restart_memreq", {127'd0, mem_req_o}, 128'd1);
        wait_rsp("hold2", 1'b0, n);
        check("hold2_line", line_o, exp_line(a));
        repeat (2) @(negedge clk);
        check("hold_nreq", 128'(grant_log.size() - gstart), 128'd8);
        check("hold_rsp_twice", 128'(rsp_cnt - rstart), 128'd2);

        // Randomized addresses, grant gaps and response latencies
        gnt_mode = 1; lat_rand = 1'b1;
        for (int i = 0; i < 24; i++) begin
            salt = $urandom();
            full_fill($sformatf("rnd%0d", i), $urandom(), 1'b0);
        end
        gnt_mode = 0; lat_rand = 1'b0;

        // Reset after two grants aborts the fill
        rstart = rsp_cnt; gstart = grant_log.size();
        req_i = 1'b1; addr_i = 32'h0000_4000; n = 0;
        while (grant_log.size() < gstart + 2 && n < 50) begin
            @(negedge clk); n++; req_i = 1'b0;
        end
        check("rst_two_grants_seen", {127'd0, (grant_log.size() >= gstart + 2)}, 128'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_rsp", {127'd0, rsp_o}, 128'd0);
        check("rst_mid_memreq", {127'd0, mem_req_o}, 128'd0);
        check("rst_mid_busy", {127'd0, busy_o}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_no_rsp", 128'(rsp_cnt - rstart), 128'd0);
        salt = $urandom();
        full_fill("after_rst", 32'h0000_5008, 1'b1);

        // Spurious rvalid while idle
        saved = line_o; rstart = rsp_cnt;
        spur_req = spur_req + 1;
        repeat (4) @(negedge clk);
        check("spur_injected", 128'(spur_done), 128'(spur_req));
        check("spur_line_kept", line_o, saved);
        check("spur_no_rsp", 128'(rsp_cnt - rstart), 128'd0);

        check("global_addr_stable", 128'(stab_err), 128'd0);
        check("global_max_outstanding", {127'd0, (max_out <= 4)}, 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
